// File: rtl/rom_addr_sequencer_if.sv
// Control/status bundle between the ROM address sequencer and its controller.
// The controller drives the master side; the sequencer is the slave.
interface rom_addr_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 16
);
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;
  logic [DIV_W-1:0]  div;
  logic [ADDR_W-1:0] address;
  logic              addr_valid;
  logic              busy;
  logic              dir;
  logic              wrap;
  logic              done;
  logic              cfg_err;

  modport master (
    output start, stop, mode, addr_lo, addr_hi, div,
    input  address, addr_valid, busy, dir, wrap, done, cfg_err
  );

  modport slave (
    input  start, stop, mode, addr_lo, addr_hi, div,
    output address, addr_valid, busy, dir, wrap, done, cfg_err
  );
endinterface

// File: rtl/rom_addr_sequencer.sv
// Sweeps a ROM address between latched bounds with a rate prescaler;
// wrap, one-shot and ping-pong modes, all outputs registered.
module rom_addr_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_addr_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] address, address_n;
  logic [DIV_W-1:0]  presc, presc_n;
  logic              dir, dir_n;
  logic              wrap, wrap_n;
  logic              done, done_n;
  logic              cfg_err, cfg_err_n;
  logic              busy;
  logic              cfg_load;

  // Configuration captured at an accepted start; held constant through RUN.
  logic [ADDR_W-1:0] lo_l;
  logic [ADDR_W-1:0] hi_l;
  logic [DIV_W-1:0]  div_l;
  logic [1:0]        mode_l;

  always_ff @(posedge clk) begin
    if (cfg_load) begin
      lo_l   <= bus.addr_lo;
      hi_l   <= bus.addr_hi;
      div_l  <= bus.div;
      mode_l <= bus.mode;
    end
  end

  always_comb begin
    state_n   = state;
    address_n = address;
    presc_n   = presc;
    dir_n     = dir;
    wrap_n    = 1'b0;
    done_n    = 1'b0;
    cfg_err_n = 1'b0;
    cfg_load  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.addr_lo <= bus.addr_hi) begin
            cfg_load  = 1'b1;
            address_n = bus.addr_lo;
            dir_n     = 1'b0;
            presc_n   = '0;
            state_n   = RUN;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      RUN: begin
        // Stop outranks a coincident advance.
        if (bus.stop) begin
          state_n = IDLE;
          presc_n = '0;
          dir_n   = 1'b0;
        end else if (presc != div_l) begin
          presc_n = presc + DIV_W'(1);
        end else begin
          presc_n = '0;
          case (mode_l)
            2'd1: begin
              if (address == hi_l) begin
                done_n  = 1'b1;
                state_n = IDLE;
              end else begin
                address_n = address + ADDR_W'(1);
              end
            end
            2'd2: begin
              if (!dir) begin
                if (address == hi_l) begin
                  // lo==hi degenerates to a constant address with a pulse per advance.
                  wrap_n = 1'b1;
                  if (hi_l > lo_l) begin
                    address_n = hi_l - ADDR_W'(1);
                    dir_n     = 1'b1;
                  end
                end else begin
                  address_n = address + ADDR_W'(1);
                end
              end else begin
                if (address == lo_l) begin
                  address_n = lo_l + ADDR_W'(1);
                  dir_n     = 1'b0;
                  wrap_n    = 1'b1;
                end else begin
                  address_n = address - ADDR_W'(1);
                end
              end
            end
            default: begin
              if (address == hi_l) begin
                address_n = lo_l;
                wrap_n    = 1'b1;
              end else begin
                address_n = address + ADDR_W'(1);
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      address <= '0;
      presc   <= '0;
      dir     <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      address <= address_n;
      presc   <= presc_n;
      dir     <= dir_n;
      wrap    <= wrap_n;
      done    <= done_n;
      cfg_err <= cfg_err_n;
      busy    <= (state_n == RUN);
    end
  end

  assign bus.address    = address;
  assign bus.addr_valid = busy;
  assign bus.busy       = busy;
  assign bus.dir        = dir;
  assign bus.wrap       = wrap;
  assign bus.done       = done;
  assign bus.cfg_err    = cfg_err;

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Randomised and directed bench for rom_addr_sequencer against a closed-form
// model of the sweep (address/status as a function of cycles since start).
module tb_rom_addr_sequencer;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int OW = AW + 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_addr_sequencer_if #(.ADDR_W(AW), .DIV_W(DW)) ifc();
  rom_addr_sequencer #(.ADDR_W(AW), .DIV_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] idle_addr;

  function automatic logic [OW-1:0] obs();
    return {ifc.address, ifc.busy, ifc.addr_valid, ifc.dir, ifc.wrap, ifc.done, ifc.cfg_err};
  endfunction

  // Ping-pong direction at step s: down on the descending half and on the lo reached by descent.
  function automatic logic pp_dir(input int d, input int s);
    int p;
    p = s % (2 * d);
    return (s > 0) && ((p == 0) || (p > d));
  endfunction

  // Expected {address,busy,addr_valid,dir,wrap,done,cfg_err} t cycles after the accepting edge.
  function automatic logic [OW-1:0] model(input int lo, input int hi, input int dv,
                                          input int md, input int t);
    int per, s, d, p, a;
    logic b, dr, wr, dn, first;
    per = dv + 1; s = t / per; d = hi - lo;
    first = (t % per == 0) && (s > 0);
    b = 1'b1; dr = 1'b0; wr = 1'b0; dn = 1'b0;
    if (md == 1) begin
      if (s <= d) a = lo + s;
      else begin
        a = hi; b = 1'b0; dn = (t == (d + 1) * per);
      end
    end else if (md == 2 && d > 0) begin
      p = s % (2 * d);
      a = (p <= d) ? lo + p : hi - (p - d);
      dr = pp_dir(d, s);
      wr = first && (pp_dir(d, s) != pp_dir(d, s - 1));
    end else begin
      a = lo + s % (d + 1);
      wr = first && (s % (d + 1) == 0);
    end
    return {AW'(a), b, b, dr, wr, dn, 1'b0};
  endfunction

  // Start a sweep, check n cycles, optionally poke start mid-run, then end with
  // endact: 0 = stay in current cycle, 1 = stop, 2 = reset.
  task automatic run_sweep(input string name, input int lo, input int hi, input int dv,
                           input int md, input int n, input int poke, input int endact);
    logic [OW-1:0] exp_v, got;
    ifc.addr_lo = AW'(lo); ifc.addr_hi = AW'(hi); ifc.div = DW'(dv); ifc.mode = 2'(md);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    exp_v = '0;
    for (int t = 0; t < n; t++) begin
      exp_v = model(lo, hi, dv, md, t);
      got = obs();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp_v);
      end
      if (t == poke) begin
        ifc.start = 1'b1; ifc.addr_lo = AW'($urandom); ifc.addr_hi = AW'($urandom);
        ifc.div = DW'($urandom); ifc.mode = 2'($urandom);
      end
      if (t < n - 1) begin
        @(negedge clk);
        ifc.start = 1'b0;
      end
    end
    idle_addr = exp_v[OW-1 -: AW];
    if (endact == 1) begin
      if (exp_v[5]) exp_v = {exp_v[OW-1 -: AW], 6'b0};
      else exp_v = model(lo, hi, dv, md, n);
      ifc.stop = 1'b1;
      @(negedge clk);
      ifc.stop = 1'b0;
    end else if (endact == 2) begin
      exp_v = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    if (endact != 0) begin
      got = obs();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s_end got=%h expected=%h", name, got, exp_v);
      end
      idle_addr = exp_v[OW-1 -: AW];
    end
  endtask

  task automatic test_reset();
    logic [OW-1:0] got;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = obs();
      n_tests++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h expected=%h", i, got, {OW{1'b0}});
      end
    end
    rst = 1'b0;
    idle_addr = '0;
  endtask

  task automatic test_legacy();
    run_sweep("legacy", 0, 600, 0, 0, 1203, -1, 1);
  endtask

  task automatic test_oneshot();
    run_sweep("oneshot", 5, 8, 2, 1, 15, -1, 1);
  endtask

  task automatic test_pingpong();
    run_sweep("pingpong", 2, 5, 0, 2, 20, -1, 1);
  endtask

  task automatic test_error();
    logic [OW-1:0] got, exp_v;
    ifc.addr_lo = AW'(7); ifc.addr_hi = AW'(3); ifc.div = '0; ifc.mode = 2'd0;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_v = {idle_addr, 5'b0, (i == 0)};
      got = obs();
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL cfg_err cyc=%0d got=%h expected=%h", i, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_degenerate();
    run_sweep("degen_wrap", 9, 9, 1, 0, 12, -1, 1);
    run_sweep("degen_pp", 9, 9, 1, 2, 8, -1, 1);
    run_sweep("degen_os", 9, 9, 1, 1, 5, -1, 1);
  endtask

  task automatic test_stop();
    run_sweep("stop_terminal", 12, 32, 3, 0, 20, -1, 1);
  endtask

  task automatic test_start_ignored();
    run_sweep("start_ignored", 100, 110, 1, 2, 40, 7, 1);
  endtask

  task automatic test_reset_mid();
    run_sweep("reset_mid", 0, 600, 0, 0, 301, -1, 2);
    run_sweep("after_reset", 3, 6, 0, 0, 10, -1, 1);
  endtask

  task automatic test_back_to_back();
    run_sweep("b2b_first", 20, 23, 1, 1, 9, -1, 0);
    run_sweep("b2b_second", 40, 42, 0, 2, 12, -1, 1);
  endtask

  task automatic test_random();
    int lo, hi, span, dv, md, len, n, poke, lim;
    for (int it = 0; it < 25; it++) begin
      span = int'($urandom_range(0, 10));
      lo = int'($urandom_range(0, 1023));
      hi = (lo + span > 1023) ? 1023 : lo + span;
      if (it % 5 == 0) begin
        hi = 1023; lo = 1023 - span;
      end
      dv = int'($urandom_range(0, 3));
      md = int'($urandom_range(0, 3));
      len = (hi - lo + 1) * (dv + 1);
      n = int'($urandom_range(2, 2 * len + 4));
      lim = (md == 1 && len < n - 1) ? len : n - 1;
      poke = int'($urandom_range(0, lim - 1));
      run_sweep("random", lo, hi, dv, md, n, poke, int'($urandom_range(1, 2)));
    end
  endtask

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.mode = 2'd0;
    ifc.addr_lo = '0; ifc.addr_hi = '0; ifc.div = '0;
    test_reset();
    test_legacy();
    test_oneshot();
    test_pingpong();
    test_error();
    test_degenerate();
    test_stop();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_addr_sequencer.md
# rom_addr_sequencer

Parametrised address generator for the waveform/lookup ROMs in the gutter-oil detection datapath. It sweeps an address between run-time programmable lower and upper bounds, with a programmable rate prescaler and three sweep modes: wrap, one-shot and ping-pong. It drives the ROM address port directly and provides status pulses to the downstream sampling and measurement logic. With lo=0, hi=600, div=0 and wrap mode it produces a free-running 0..600 sweep at one address per clock.

## Interface
- ADDR_W, 10: address width; bounds and address are unsigned ADDR_W bits.
- DIV_W, 16: prescaler width.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start pulse; sampled only in IDLE.
- stop  in  1  abort request; sampled only in RUN.
- mode  in  2  sweep mode: 0 wrap, 1 one-shot, 2 ping-pong, 3 treated as wrap.
- addr_lo  in  ADDR_W  lower bound, latched on accepted start.
- addr_hi  in  ADDR_W  upper bound, latched on accepted start.
- div  in  DIV_W  each address is held for div+1 cycles; latched on accepted start.
- address  out  ADDR_W  registered ROM address.
- addr_valid  out  1  high while address is live (RUN).
- busy  out  1  high in RUN.
- dir  out  1  0 = counting up, 1 = counting down (ping-pong only; 0 otherwise).
- wrap  out  1  1-cycle pulse on wrap-around or direction reversal.
- done  out  1  1-cycle pulse when a one-shot sweep completes.
- cfg_err  out  1  1-cycle pulse when start is rejected.

## Operation
- Reset values: address=0, addr_valid=0, busy=0, dir=0, wrap=0, done=0, cfg_err=0, prescaler=0, state IDLE.
- rst has priority over all other inputs at any time, including mid-sweep.
- States: IDLE and RUN.
- IDLE, start=1, addr_lo<=addr_hi:
  - latch lo, hi, mode and div;
  - address<=lo, dir<=0, prescaler<=0;
  - busy and addr_valid go to 1; next state RUN.
- IDLE, start=1, addr_lo>addr_hi: cfg_err pulse; the block stays in IDLE; address is unchanged.
- IDLE: stop is ignored. RUN: start is ignored, and changes on the config inputs have no effect.
- RUN, prescaler:
  - counts 0..div_l;
  - an "advance" occurs in the cycle where prescaler==div_l, and the prescaler then returns to 0.
- Advance, mode 0/3:
  - address==hi: address<=lo with a wrap pulse;
  - otherwise: address+1.
- Advance, mode 1:
  - address==hi: done pulse; IDLE with busy=0 and addr_valid=0; address holds hi;
  - otherwise: address+1.
- Advance, mode 2, dir=0:
  - address==hi and hi>lo: address<=hi-1, dir<=1, wrap pulse;
  - otherwise: address+1.
- Advance, mode 2, dir=1:
  - address==lo: address<=lo+1, dir<=0, wrap pulse;
  - otherwise: address-1.
- lo==hi:
  - address is constant;
  - modes 0 and 2: wrap pulses on every advance; dir stays 0;
  - mode 1: done on the first advance.
- RUN, stop=1:
  - IDLE next edge with busy=0 and addr_valid=0;
  - address holds its value; no done or wrap pulse; prescaler cleared;
  - stop wins over an advance in the same cycle.
- Arithmetic is unsigned. The address never leaves [lo,hi], so no overflow occurs even when hi = 2^ADDR_W-1.

## Timing
- start sampled at edge k: address=lo, busy=1 and addr_valid=1 from edge k.
- First advance at edge k+div+1. Every address is held exactly div+1 cycles.
- Mode 0 period: (hi-lo+1)(div+1) cycles.
- Mode 2 period: 2(hi-lo)(div+1) cycles for hi>lo.
- Pulses are registered at the same edge as the address update they describe:
  - wrap is high during the first cycle of the new address;
  - done is high in the first IDLE cycle, together with busy=0;
  - cfg_err is high in the cycle after the rejected start.
- Back-to-back operation: start may be accepted in the cycle done is high, giving a one-idle-cycle gap.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Legacy sweep: lo=0, hi=600, div=0, mode 0, start pulse -> address steps 0,1,…,600,0; wrap is high only on each return to 0; period 601 cycles; busy stays high.
- Prescaler/one-shot: lo=5, hi=8, div=2, mode 1 -> address sequence 5,5,5,6,6,6,7,7,7,8,8,8; then done=1 for one cycle, busy=0, address stays 8.
- Ping-pong: lo=2, hi=5, div=0, mode 2 -> address 2,3,4,5,4,3,2,3…; dir=1 over the 4,3,2 segment; wrap pulses on entering 4 and on entering 3.
- Degenerate/error: start with lo=7, hi=3 -> cfg_err one cycle, busy stays 0. Then lo=hi=9, mode 0, div=1 -> address 9 constant, wrap every 2 cycles.
- Stop and priority:
  - stop asserted in the prescaler's terminal cycle at address 0x10 (mode 0) -> IDLE, address 0x10, no wrap or done.
  - start while RUN is ignored.
- Reset mid-sweep: rst=1 at address 300 -> at the next edge all outputs take their reset values; a start 1 cycle later is accepted normally.
